// File: rtl/apb_arbiter_pkg.sv
// Shared types for the two-requester APB arbiter: transfer FSM states,
// requester index type and the round-robin selection rule.
package apb_arbiter_pkg;

    // Transfer sequencing on the shared downstream bus
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    // Index of an upstream requester (0 or 1)
    typedef logic req_idx_t;

    // Requester 1 counts as "granted last" out of reset, so requester 0
    // wins the very first tie.
    localparam req_idx_t LAST_GRANT_RESET = 1'b1;

    // Round-robin choice: on a tie the requester not granted last wins;
    // otherwise whichever one is asking.
    function automatic req_idx_t rr_pick(input logic [1:0] req, input req_idx_t last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1] ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/APB.sv
// APB bus bundle shared by the upstream requesters and the downstream bus.
// The requester side also supplies pclk/preset_n to the completer.
interface APB #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    pclk;
    logic                    preset_n;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pwakeup;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport requester (
        output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot, pwakeup,
        input  prdata, pready, pslverr
    );

    modport completer (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot, pwakeup,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_rr_picker.sv
// Two-way round-robin grant selector. Purely combinational; the caller
// qualifies the result with "any request pending".
module apb_rr_picker
    import apb_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output req_idx_t   grant
);

    // Pick the next requester, alternating on contention
    always_comb begin
        grant = rr_pick(req, last);
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter in front of one shared downstream APB bus.
// A granted transfer is registered in IDLE, replayed downstream as
// SETUP/ACCESS, and the response is returned to the requester in DONE.
// Optional feature: define APB_ARBITER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES cycles with an error response.
module apb_arbiter
    import apb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    APB.completer  req0,
    APB.completer  req1,
    APB.requester  down
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_t              state_reg;
    arb_state_t              state_next;
    req_idx_t                grant_reg;
    req_idx_t                last_grant_reg;
    req_idx_t                pick_grant;
    logic [1:0]              req_vec;
    logic                    timeout_hit;

    logic [ADDR_WIDTH-1:0]   paddr_reg;
    logic                    pwrite_reg;
    logic [DATA_WIDTH-1:0]   pwdata_reg;
    logic [STRB_WIDTH-1:0]   pstrb_reg;
    logic [2:0]              pprot_reg;
    logic [DATA_WIDTH-1:0]   prdata_reg;
    logic                    pslverr_reg;

    logic                    deliver0;
    logic                    deliver1;

    assign req_vec = {req1.psel, req0.psel};

    apb_rr_picker u_picker (
        .req   (req_vec),
        .last  (last_grant_reg),
        .grant (pick_grant)
    );

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] timeout_cnt_reg;

    // Count ACCESS cycles; cleared while in SETUP so it is zero on entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == ACCESS) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end

    // A completer answering on the last allowed cycle still wins
    assign timeout_hit = (state_reg == ACCESS) && !down.pready &&
                         (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state decode of the transfer sequencer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req_vec) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (down.pready || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, grant bookkeeping, captured request fields and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= LAST_GRANT_RESET;
            paddr_reg      <= '0;
            pwrite_reg     <= 1'b0;
            pwdata_reg     <= '0;
            pstrb_reg      <= '0;
            pprot_reg      <= '0;
            prdata_reg     <= '0;
            pslverr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        grant_reg      <= pick_grant;
                        last_grant_reg <= pick_grant;
                        paddr_reg      <= pick_grant ? req1.paddr  : req0.paddr;
                        pwrite_reg     <= pick_grant ? req1.pwrite : req0.pwrite;
                        pwdata_reg     <= pick_grant ? req1.pwdata : req0.pwdata;
                        pstrb_reg      <= pick_grant ? req1.pstrb  : req0.pstrb;
                        pprot_reg      <= pick_grant ? req1.pprot  : req0.pprot;
                    end
                end
                ACCESS: begin
                    if (down.pready) begin
                        prdata_reg  <= down.prdata;
                        pslverr_reg <= down.pslverr;
                    end else if (timeout_hit) begin
                        prdata_reg  <= '0;
                        pslverr_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Downstream bus is a pure function of state and captured fields, so
    // reset removes psel/penable immediately.
    assign down.pclk     = clk;
    assign down.preset_n = rst_n;
    assign down.psel     = (state_reg == SETUP) || (state_reg == ACCESS);
    assign down.penable  = (state_reg == ACCESS);
    assign down.paddr    = paddr_reg;
    assign down.pwrite   = pwrite_reg;
    assign down.pwdata   = pwdata_reg;
    assign down.pstrb    = pstrb_reg;
    assign down.pprot    = pprot_reg;
    assign down.pwakeup  = req0.pwakeup | req1.pwakeup;

    // Response goes only to the granted requester, and only if it is still
    // in its access phase; a requester that walked away gets nothing.
    assign deliver0 = (state_reg == DONE) && (grant_reg == 1'b0) && req0.psel && req0.penable;
    assign deliver1 = (state_reg == DONE) && (grant_reg == 1'b1) && req1.psel && req1.penable;

    assign req0.pready  = deliver0;
    assign req0.prdata  = deliver0 ? prdata_reg : '0;
    assign req0.pslverr = deliver0 & pslverr_reg;
    assign req1.pready  = deliver1;
    assign req1.prdata  = deliver1 ? prdata_reg : '0;
    assign req1.pslverr = deliver1 & pslverr_reg;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed testbench for apb_arbiter: two scripted upstream requesters and a
// configurable downstream completer. Timeout scenario runs only when
// APB_ARBITER_TIMEOUT_EN is defined.
module tb_apb_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    APB #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) req0_if ();
    APB #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) req1_if ();
    APB #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) down_if ();

    apb_arbiter #(
        .TIMEOUT_CYCLES (16),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0_if),
        .req1  (req1_if),
        .down  (down_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Completer model knobs
    int          wait_states   = 0;
    bit          never_respond = 1'b0;
    logic [31:0] resp_data     = 32'h0;
    logic        resp_err      = 1'b0;
    int          acc_cnt       = 0;

    always_ff @(posedge clk) begin
        if (down_if.psel && down_if.penable && !down_if.pready) acc_cnt <= acc_cnt + 1;
        else                                                    acc_cnt <= 0;
    end

    always_comb begin
        down_if.pready  = down_if.psel && down_if.penable && !never_respond && (acc_cnt >= wait_states);
        down_if.prdata  = down_if.pready ? resp_data : 32'h0;
        down_if.pslverr = down_if.pready && resp_err;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int idx, input logic sel, input logic en, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (idx == 0) begin
            req0_if.psel = sel; req0_if.penable = en; req0_if.pwrite = wr;
            req0_if.paddr = addr; req0_if.pwdata = wdata; req0_if.pstrb = 4'hF; req0_if.pprot = 3'b000;
        end else begin
            req1_if.psel = sel; req1_if.penable = en; req1_if.pwrite = wr;
            req1_if.paddr = addr; req1_if.pwdata = wdata; req1_if.pstrb = 4'hF; req1_if.pprot = 3'b000;
        end
    endtask

    task automatic set_en(input int idx, input logic en);
        if (idx == 0) req0_if.penable = en;
        else          req1_if.penable = en;
    endtask

    // Issue one transfer in the current (IDLE) cycle and wait for pready.
    // lat = cycles from the upstream setup cycle to the pready cycle.
    // Returns in the IDLE cycle following DONE.
    task automatic run_xfer(input string tag, input int idx, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rdata,
                            output logic err, output logic other_rdy);
        bit done = 1'b0;
        lat = 0; rdata = 32'h0; err = 1'b0; other_rdy = 1'b0;
        drive_req(idx, 1'b1, 1'b0, wr, addr, wdata);
        for (int c = 0; c < 64 && !done; c++) begin
            tick();
            lat++;
            set_en(idx, 1'b1);
            if (idx == 0 && req0_if.pready) begin
                done = 1'b1; rdata = req0_if.prdata; err = req0_if.pslverr; other_rdy = req1_if.pready;
            end else if (idx == 1 && req1_if.pready) begin
                done = 1'b1; rdata = req1_if.prdata; err = req1_if.pslverr; other_rdy = req0_if.pready;
            end
        end
        check({tag, "_completed"}, 64'(done), 64'd1);
        drive_req(idx, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        other_rdy;

    initial begin
        rst_n = 1'b0;
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        req0_if.pwakeup = 1'b0;
        req1_if.pwakeup = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_down_psel",    64'(down_if.psel),    64'd0);
        check("rst_down_penable", 64'(down_if.penable), 64'd0);
        check("rst_down_pwrite",  64'(down_if.pwrite),  64'd0);
        check("rst_down_paddr",   64'(down_if.paddr),   64'd0);
        check("rst_down_pwdata",  64'(down_if.pwdata),  64'd0);
        check("rst_down_pstrb",   64'(down_if.pstrb),   64'd0);
        check("rst_req0_pready",  64'(req0_if.pready),  64'd0);
        check("rst_req1_pready",  64'(req1_if.pready),  64'd0);
        rst_n = 1'b1;

        // ---- tie after reset: req0 first, then req1, then req0 again ----
        resp_data = 32'h0000CAFE;
        drive_req(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h11111111);
        drive_req(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        tick();
        check("tie1_setup_psel",  64'(down_if.psel),    64'd1);
        check("tie1_setup_paddr", 64'(down_if.paddr),   64'h10);
        set_en(0, 1'b1); set_en(1, 1'b1);
        tick();
        check("tie1_access_en",   64'(down_if.penable), 64'd1);
        tick();
        check("tie1_req0_pready", 64'(req0_if.pready),  64'd1);
        check("tie1_req1_idle",   64'(req1_if.pready),  64'd0);
        drive_req(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h33333333);   // req0 back-to-back
        tick();
        check("tie2_idle_psel",   64'(down_if.psel),    64'd0);
        set_en(0, 1'b1);
        tick();
        check("tie2_setup_paddr", 64'(down_if.paddr),   64'h20);
        check("tie2_setup_pwrite",64'(down_if.pwrite),  64'd0);
        tick();
        tick();
        check("tie2_req1_pready", 64'(req1_if.pready),  64'd1);
        check("tie2_req1_prdata", 64'(req1_if.prdata),  64'h0000CAFE);
        check("tie2_req0_wait",   64'(req0_if.pready),  64'd0);
        drive_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check("tie3_setup_paddr", 64'(down_if.paddr),   64'h30);
        tick();
        tick();
        check("tie3_req0_pready", 64'(req0_if.pready),  64'd1);
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // ---- req0 write, zero wait states, cycle-exact ----
        wait_states = 0; resp_err = 1'b0;
        drive_req(0, 1'b1, 1'b0, 1'b1, 32'h000104, 32'hDEADBEEF);
        tick();
        check("w_setup_psel",    64'(down_if.psel),    64'd1);
        check("w_setup_penable", 64'(down_if.penable), 64'd0);
        check("w_setup_paddr",   64'(down_if.paddr),   64'h104);
        check("w_setup_pwrite",  64'(down_if.pwrite),  64'd1);
        check("w_setup_pwdata",  64'(down_if.pwdata),  64'hDEADBEEF);
        check("w_setup_pstrb",   64'(down_if.pstrb),   64'hF);
        set_en(0, 1'b1);
        tick();
        check("w_access_psel",   64'(down_if.psel),    64'd1);
        check("w_access_penable",64'(down_if.penable), 64'd1);
        check("w_access_paddr",  64'(down_if.paddr),   64'h104);
        tick();
        check("w_done_req0_rdy", 64'(req0_if.pready),  64'd1);
        check("w_done_pslverr",  64'(req0_if.pslverr), 64'd0);
        check("w_done_req1_rdy", 64'(req1_if.pready),  64'd0);
        check("w_done_down_psel",64'(down_if.psel),    64'd0);
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("w_idle_req0_rdy", 64'(req0_if.pready),  64'd0);

        // ---- pwakeup OR ----
        req1_if.pwakeup = 1'b1; #1;
        check("wake_req1", 64'(down_if.pwakeup), 64'd1);
        req1_if.pwakeup = 1'b0; req0_if.pwakeup = 1'b1; #1;
        check("wake_req0", 64'(down_if.pwakeup), 64'd1);
        req0_if.pwakeup = 1'b0; #1;
        check("wake_none", 64'(down_if.pwakeup), 64'd0);
        tick();

        // ---- req1 read with 5 wait states ----
        wait_states = 5; resp_data = 32'h12345678;
        run_xfer("rd5", 1, 1'b0, 32'h000200, 32'h0, lat, rdata, err, other_rdy);
        check("rd5_latency", 64'(lat),       64'd8);
        check("rd5_prdata",  64'(rdata),     64'h12345678);
        check("rd5_pslverr", 64'(err),       64'd0);
        check("rd5_req0_rdy",64'(other_rdy), 64'd0);

        // ---- slave error on a write, then a clean read ----
        wait_states = 0; resp_err = 1'b1;
        run_xfer("err", 0, 1'b1, 32'h500, 32'h55AA55AA, lat, rdata, err, other_rdy);
        check("err_latency", 64'(lat), 64'd3);
        check("err_pslverr", 64'(err), 64'd1);
        resp_err = 1'b0; resp_data = 32'hA5A5A5A5;
        run_xfer("ok", 0, 1'b0, 32'h504, 32'h0, lat, rdata, err, other_rdy);
        check("ok_pslverr", 64'(err),   64'd0);
        check("ok_prdata",  64'(rdata), 64'hA5A5A5A5);

        // ---- reset pulse during ACCESS ----
        wait_states = 3;
        drive_req(0, 1'b1, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D);
        tick();
        set_en(0, 1'b1);
        tick();
        check("rstmid_access", 64'(down_if.penable), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_psel_async",    64'(down_if.psel),    64'd0);
        check("rstmid_penable_async", 64'(down_if.penable), 64'd0);
        check("rstmid_paddr",         64'(down_if.paddr),   64'd0);
        drive_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("rstmid_no_pready", 64'(req0_if.pready), 64'd0);
        rst_n = 1'b1;
        wait_states = 0; resp_data = 32'h0BADCAFE;
        run_xfer("post_rst", 0, 1'b0, 32'h304, 32'h0, lat, rdata, err, other_rdy);
        check("post_rst_latency", 64'(lat),   64'd3);
        check("post_rst_prdata",  64'(rdata), 64'h0BADCAFE);

`ifdef APB_ARBITER_TIMEOUT_EN
        // ---- completer never answers: abort after 16 ACCESS cycles ----
        never_respond = 1'b1; resp_data = 32'hFFFFFFFF;
        run_xfer("tmo", 1, 1'b0, 32'h400, 32'h0, lat, rdata, err, other_rdy);
        check("tmo_latency", 64'(lat),   64'd18);
        check("tmo_pslverr", 64'(err),   64'd1);
        check("tmo_prdata",  64'(rdata), 64'd0);
        check("tmo_psel_dropped", 64'(down_if.psel), 64'd0);
        never_respond = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, ACCESS-phase cycles before abort; only used with APB_ARBITER_TIMEOUT_EN.
REQ-002 Port: clk  in  1  single clock for all logic; drives down.pclk.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low; drives down.preset_n.
REQ-004 Port: req0  APB.completer  bus  upstream requester 0 (management bridge).
REQ-005 Port: req1  APB.completer  bus  upstream requester 1 (second management master).
REQ-006 Port: down  APB.requester  bus  shared downstream APB bus.
REQ-007 All three buses SHALL share the same ADDR_WIDTH and DATA_WIDTH.

Function
REQ-008 The FSM SHALL have four states: IDLE, SETUP, ACCESS, DONE.
REQ-009 IDLE: if any reqN.psel=1, grant one requester; register its paddr, pwrite, pwdata, pstrb and pprot; go to SETUP next cycle.
REQ-010 Tie (both psel=1 in IDLE): grant the requester not granted last; last_grant resets to 1, so req0 wins the first tie.
REQ-011 SETUP: down.psel=1, down.penable=0 with the registered fields, for exactly one cycle; then go to ACCESS.
REQ-012 ACCESS: down.psel=1, down.penable=1, fields held stable until down.pready=1.
REQ-013 On down.pready=1 in ACCESS: register prdata and pslverr, drop down.psel and down.penable next cycle, and go to DONE.
REQ-014 DONE: the granted reqN.pready=1 for exactly one cycle with the registered prdata/pslverr; then return to IDLE.
REQ-015 Non-granted requester: pready=0, prdata=0, pslverr=0 at all times.
REQ-016 Requester wait states: upstream psel/penable SHALL stay asserted until DONE, per APB.
REQ-017 Minimum latency: upstream setup at cycle N gives down SETUP at N+1, ACCESS at N+2, and upstream pready at N+3 for a zero-wait-state completer.
REQ-018 A new request is sampled only in IDLE, never in DONE; no double issue of a completed transfer.
REQ-019 A requester dropping psel before DONE is a protocol violation; the transfer already issued SHALL complete downstream, and the result is discarded.
REQ-020 down.pwakeup SHALL equal req0.pwakeup OR req1.pwakeup.
REQ-021 Back-to-back requests from both requesters SHALL alternate grants, so neither requester starves.

Reset
REQ-022 Asynchronous assertion of rst_n=0 SHALL force IDLE, last_grant=1, and all registered fields and counters to 0.
REQ-023 During reset: down.psel, down.penable and down.pwrite = 0; paddr, pwdata and pstrb = 0; every reqN.pready, prdata and pslverr = 0.
REQ-024 Reset mid-transfer SHALL abandon the transfer with no upstream pready.
REQ-025 The first grant after release SHALL occur no earlier than the first clk edge with rst_n=1.

Configuration
REQ-026 Macro APB_ARBITER_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle.
- Defined: if it reaches TIMEOUT_CYCLES-1 with down.pready=0, drop down.psel/down.penable and go to DONE with upstream pslverr=1 and prdata=0.
- Defined: a down.pready arriving on that same cycle takes precedence and completes normally.
REQ-027 Macro undefined: no counter is instantiated, and ACCESS waits indefinitely for down.pready.

Structure
REQ-028 Shared package apb_arbiter_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS, DONE) and a requester-index typedef.
REQ-029 Round-robin grant selection SHALL be a sub-module, apb_rr_picker: inputs req[1:0] and last, output grant index.

Verification
REQ-030 req0 write paddr=0x000104, pwdata=0xDEADBEEF, zero-wait completer -> down SETUP at N+1, ACCESS at N+2, req0.pready at N+3; req1.pready stays 0.
REQ-031 req0 and req1 both assert psel in the same cycle after reset -> req0 granted first, req1 granted in the IDLE immediately after req0's DONE.
REQ-032 req1 read paddr=0x000200, completer inserts 5 wait states returning 0x12345678 -> req1.prdata=0x12345678 and pslverr=0, with pready at N+8.
REQ-033 With APB_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, and a completer that never responds -> down.psel drops after 16 ACCESS cycles, and the requester gets pready=1, pslverr=1, prdata=0.
REQ-034 rst_n pulsed low during ACCESS -> down.psel=0 immediately (asynchronously), no upstream pready; the next request after release completes normally.
REQ-035 Completer returns pslverr=1 on a write -> the granted requester sees pslverr=1 in DONE, and the next transfer's pslverr=0.
